// File: rtl/bidir_ram.sv
// bidir_ram
//   Single-port 2^n x r static RAM with classic active-low SRAM controls and a
//   shared tri-state data bus. Writes are clocked. Reads are combinational
//   (m=0) or pass through an m-stage register pipe (m=1..4).
//
//   Parameters
//     n : address width, depth = 2^n words
//     m : read latency in clocks (0 = combinational, 1..4 = registered)
//     r : data word width
//
//   Ports
//     clk   : rising-edge clock
//     reset : asynchronous, active-high; clears array and read pipe
//     CS    : chip select, active low
//     WE    : write enable, active low (wins over OE)
//     OE    : output enable, active low
//     ADDR  : word address. The legacy pin list numbers the address pins
//             MSB-first (bit 0 = MSB). Only the numeric word value matters
//             here, so the vector is declared with the usual descending range.
//     DATA  : bidirectional data; driven only during an enabled read,
//             high-Z otherwise and always high-Z while reset is high
module bidir_ram #(
  parameter int n = 8,
  parameter int m = 0,
  parameter int r = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         CS,
  input  logic         WE,
  input  logic         OE,
  input  logic [n-1:0] ADDR,
  inout  wire  [r-1:0] DATA
);

  localparam int DEPTH = 1 << n;

  logic             wr_en;
  logic             rd_en;
  logic [DEPTH-1:0] wr_sel;
  logic [r-1:0]     data_in;
  logic [r-1:0]     rd_word;
  logic [r-1:0]     out_word;
  logic [r-1:0]     mem_reg [DEPTH];

  // A write wins over OE; deselect (CS=1) ignores both.
  assign wr_en   = !CS && !WE;
  assign rd_en   = !CS &&  WE && !OE;
  assign data_in = DATA;
  assign rd_word = mem_reg[ADDR];

  // One-hot word select for the write port.
  always_comb begin
    wr_sel       = '0;
    wr_sel[ADDR] = wr_en;
  end

  // The array must clear asynchronously on reset, so each word is its own
  // register rather than a RAM macro.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mem_reg[gi] <= '0;
        end else if (wr_sel[gi]) begin
          mem_reg[gi] <= data_in;
        end
      end
    end
  endgenerate

  // Read path: either straight from the array or through an m-stage pipe
  // that only advances on edges where the read is enabled.
  generate
    if (m == 0) begin : g_comb_read
      assign out_word = rd_word;
    end else begin : g_pipe_read
      logic [r-1:0] pipe_reg [m];

      for (genvar gi = 0; gi < m; gi++) begin : g_stage
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            pipe_reg[gi] <= '0;
          end else if (rd_en) begin
            if (gi == 0) begin
              pipe_reg[gi] <= rd_word;
            end else begin
              pipe_reg[gi] <= pipe_reg[(gi == 0) ? 0 : gi - 1];
            end
          end
        end
      end

      assign out_word = pipe_reg[m-1];
    end
  endgenerate

  // Bus turn-on/off follows the pins combinationally; reset forces release.
  assign DATA = (rd_en && !reset) ? out_word : {r{1'bz}};

endmodule

// File: tb/tb_bidir_ram.sv
module tb_bidir_ram;

    logic       clk = 1'b0;
    logic       reset;

    logic       cs_a, we_a, oe_a;
    logic [7:0] addr_a;
    logic       drv_en_a;
    logic [7:0] drv_a;
    tri1  [7:0] bus_a;

    logic       cs_b, we_b, oe_b;
    logic [7:0] addr_b;
    logic       drv_en_b;
    logic [7:0] drv_b;
    tri1  [7:0] bus_b;

    assign bus_a = drv_en_a ? drv_a : 8'bz;
    assign bus_b = drv_en_b ? drv_b : 8'bz;

    always #5 clk = ~clk;

    bidir_ram #(.n(8), .m(0), .r(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .CS    (cs_a),
        .WE    (we_a),
        .OE    (oe_a),
        .ADDR  (addr_a),
        .DATA  (bus_a)
    );

    bidir_ram #(.n(8), .m(2), .r(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .CS    (cs_b),
        .WE    (we_b),
        .OE    (oe_b),
        .ADDR  (addr_b),
        .DATA  (bus_b)
    );

    typedef struct {
        string      name;
        logic       sel;
        logic [7:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            chk_t       item;
            logic [7:0] got;
            item = sb.pop_front();
            got  = item.sel ? bus_b : bus_a;
            n_checks++;
            if (got !== item.exp) begin
                n_fail++;
                $display("FAIL %s: bus=%02h expected=%02h", item.name, got, item.exp);
            end else begin
                $display("ok   %s: bus=%02h", item.name, got);
            end
        end
    end

    initial begin
        #100000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: wait expired, %0d checks pending", sb.size());
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic check_now(input string name, input logic sel, input logic [7:0] exp);
        logic [7:0] got;
        got = sel ? bus_b : bus_a;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: bus=%02h expected=%02h", name, got, exp);
        end else begin
            $display("ok   %s: bus=%02h", name, got);
        end
    endtask

    task automatic expect_bus(input string name, input logic sel, input logic [7:0] exp);
        chk_t item;
        item.name = name;
        item.sel  = sel;
        item.exp  = exp;
        sb.push_back(item);
    endtask

    task automatic pins_a(input logic cs, input logic we, input logic oe,
                          input logic [7:0] addr, input logic den, input logic [7:0] d);
        cs_a     = cs;
        we_a     = we;
        oe_a     = oe;
        addr_a   = addr;
        drv_en_a = den;
        drv_a    = d;
    endtask

    task automatic probe_a(input string name, input logic cs, input logic we, input logic oe,
                           input logic [7:0] addr, input logic den, input logic [7:0] d,
                           input logic [7:0] exp);
        @(posedge clk);
        #1;
        pins_a(cs, we, oe, addr, den, d);
        expect_bus(name, 1'b0, exp);
        @(negedge clk);
        #1;
        pins_a(1'b1, 1'b1, 1'b1, addr, 1'b0, 8'h00);
    endtask

    task automatic read_a(input logic [7:0] addr, input logic [7:0] exp, input string tag);
        @(posedge clk);
        #1;
        pins_a(1'b0, 1'b1, 1'b0, addr, 1'b0, 8'h00);
        expect_bus($sformatf("%s_%02h", tag, addr), 1'b0, exp);
    endtask

    initial begin
        logic [7:0] rst_addrs [4];
        rst_addrs[0] = 8'h00;
        rst_addrs[1] = 8'h7F;
        rst_addrs[2] = 8'hFF;
        rst_addrs[3] = 8'h22;

        reset = 1'b1;
        pins_a(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
        cs_b = 1'b1; we_b = 1'b1; oe_b = 1'b1; addr_b = 8'h00; drv_en_b = 1'b0; drv_b = 8'h00;

        @(posedge clk);
        #1;
        pins_a(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        #1;
        check_now("reset_bus_z_now", 1'b0, 8'hFF);
        expect_bus("reset_bus_z", 1'b0, 8'hFF);
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_bus("reset_rd_00", 1'b0, 8'h00);

        for (int a = 0; a < 256; a++) begin
            @(posedge clk);
            #1;
            pins_a(1'b0, 1'b0, 1'b1, 8'(a), 1'b1, (a % 2 == 1) ? 8'h55 : 8'hAA);
        end
        for (int a = 0; a < 256; a++) begin
            read_a(8'(a), (a % 2 == 1) ? 8'h55 : 8'hAA, "fill_rd");
        end

        probe_a("release_cs_z",  1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 8'h00, 8'hFF);
        probe_a("release_oe_z",  1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 8'h00, 8'hFF);
        probe_a("release_we_z",  1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 8'h00, 8'hFF);
        probe_a("release_cs_3c", 1'b1, 1'b1, 1'b0, 8'h02, 1'b1, 8'h3C, 8'h3C);
        probe_a("release_oe_3c", 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 8'h3C, 8'h3C);
        probe_a("release_we_3c", 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 8'h3C, 8'h3C);

        @(posedge clk);
        #1;
        pins_a(1'b0, 1'b0, 1'b0, 8'h40, 1'b1, 8'h12);
        expect_bus("wrprio_bus", 1'b0, 8'h12);
        read_a(8'h40, 8'h12, "wrprio_rd");

        @(posedge clk);
        #1;
        pins_a(1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 8'hFF);
        read_a(8'h10, 8'hAA, "deselect_rd");

        @(posedge clk);
        #1;
        pins_a(1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 8'h00);
        #2;
        reset = 1'b1;
        #0.5;
        check_now("areset_bus_z_now", 1'b0, 8'hFF);
        expect_bus("areset_bus_z", 1'b0, 8'hFF);
        @(negedge clk);
        #1;
        pins_a(1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 8'h77);
        @(posedge clk);
        #1;
        pins_a(1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_a(rst_addrs[i], 8'h00, "areset_rd");
        end
        @(posedge clk);
        #1;
        pins_a(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);

        cs_b = 1'b0; we_b = 1'b0; oe_b = 1'b1; addr_b = 8'h05; drv_en_b = 1'b1; drv_b = 8'hC3;
        @(posedge clk);
        #1;
        cs_b = 1'b0; we_b = 1'b1; oe_b = 1'b0; drv_en_b = 1'b0;
        expect_bus("lat_edge0", 1'b1, 8'h00);
        @(posedge clk);
        #1;
        expect_bus("lat_edge1", 1'b1, 8'h00);
        @(posedge clk);
        #1;
        expect_bus("lat_edge2", 1'b1, 8'hC3);
        @(negedge clk);
        #1;
        cs_b = 1'b1; we_b = 1'b1; oe_b = 1'b1;

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bidir_ram.md
# bidir_ram

Single-port, 2^n-word by r-bit static RAM with classic active-low SRAM controls (chip select, write enable, output enable) and one bidirectional data bus. Writes and the optional read pipeline are clocked; the memory sits on a shared tri-state bus, so it drives DATA only during an enabled read. It is the local storage block for the branch-predictor datapath, holding pattern/counter tables.

## Interface
- n, default 8: address width; depth = 2^n words.
- m, default 0: read latency in clock cycles. 0 means combinational read; 1–4 means registered read. Values above 4 are not supported.
- r, default 8: data word width.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- CS  input  1  chip select, active low.
- WE  input  1  write enable, active low.
- OE  input  1  output enable, active low.
- ADDR  input  [0:n-1]  word address; bit 0 is the MSB.
- DATA  inout  r  bidirectional data bus; high-Z when not reading.

One clock; reset is asynchronous and active-high.

## Operation
- Storage is a 2^n × r array. Every address 0..2^n−1 is valid. There is no wrap or aliasing inside the block.
- Write:
  - Happens on a rising clk edge when CS=0 and WE=0.
  - The word at ADDR is loaded with the DATA input value.
  - OE is ignored during a write.
- Read enable (rd_en) is CS=0, WE=1 and OE=0.
- DATA drive:
  - DATA is driven only while rd_en is true, evaluated combinationally from the current pins.
  - Otherwise DATA is high-Z, and always high-Z while reset=1.
  - Write has priority over OE: with CS=0, WE=0 and OE=0, the RAM does not drive DATA.
- Read data with m=0: the driven value is mem[ADDR], combinational from ADDR and array contents. A write to the same address is visible after the write edge.
- Read data with m>0:
  - mem[ADDR] is sampled at each rising edge where rd_en=1 and shifted through an m-stage register pipe.
  - The last stage is driven while rd_en holds.
  - The pipe advances only on edges where rd_en=1.
- Reset:
  - Asserting reset asynchronously clears every array word to 0 and clears all read-pipe stages to 0.
  - While reset=1, writes are blocked.
  - A write edge coincident with reset assertion is discarded.
- CS=1 ignores WE/OE: no write, no drive, and the pipe holds.

## Timing
- Write latency: data is stored at the rising edge where CS=0 and WE=0.
  - m=0: readable combinationally immediately after that edge.
  - m>0: readable m rising edges of continuous rd_en later.
- The bus master must present DATA, ADDR and the controls stable around the rising edge. The master's typical pattern is:
  - drop WE at the falling edge;
  - sample at the rising edge;
  - release WE after the edge.
- DATA turn-on and turn-off follow the control pins combinationally, with no clock dependency.
- Reset release: the first write may occur on the first rising edge after reset deasserts.
- All outputs at reset: DATA = Z; array = 0; pipe = 0.
- Back-to-back writes to consecutive addresses, one per cycle, are supported indefinitely.

## Test plan
- Fill and read, default parameters:
  - Write 0xAA to even and 0x55 to odd addresses, 0x00 through 0xFF, one per cycle.
  - Then read all 256 with CS=0, OE=0, WE=1.
  - Required: each read returns 0xAA or 0x55 matching address parity, and address 0xFF holds 0x55.
- Bus release:
  - With CS=1, or OE=1, or WE=0, DATA must read Z from the RAM side.
  - A concurrent master drive of 0x3C must be seen unaltered.
- Write priority:
  - CS=0, OE=0, WE=0, master drives 0x12 to address 0x40.
  - Required: no contention (DATA=0x12), and a later read of 0x40 returns 0x12.
- Async reset:
  - After the fill, pulse reset mid-cycle, away from the clock edge.
  - Required: DATA=Z immediately, and reads of 0x00, 0x7F and 0xFF all return 0x00.
  - A write attempted while reset=1 leaves the word at 0.
- Latency, m=2:
  - Write 0xC3 to address 0x05, then hold a read of 0x05.
  - Required: 0xC3 appears on DATA after exactly 2 rising edges of rd_en; the pipe value was 0x00 before that.
- Chip deselect:
  - With CS=1 and WE=0 pulsed on address 0x10 with DATA=0xFF, a subsequent read of 0x10 returns its prior value.
